// File: rtl/linked_list_pkg.sv
// Shared widths and list-id type for the multi-list buffer blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package linked_list_pkg;

    localparam int LL_NUM_ELEMS = 4;
    localparam int LL_NUM_LISTS = 2;

    // Index width that never collapses to zero for single-entry sizes.
    function automatic int ll_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LL_PTR_WIDTH = ll_width(LL_NUM_ELEMS);
    localparam int LL_SEL_WIDTH = ll_width(LL_NUM_LISTS);

    typedef logic [LL_SEL_WIDTH-1:0] list_id_t;

endpackage

// File: rtl/linked_list_reader_rr_arbiter.sv
// Round-robin picker: first requesting list after the last granted one.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports: req (one bit per list), last (previous grant index),
//        gnt (granted index, 0 when nothing requests), gnt_vld (any request).
module rr_arbiter
    import linked_list_pkg::*;
#(
    parameter int NUM_LISTS = LL_NUM_LISTS,
    parameter int SEL_WIDTH = ll_width(NUM_LISTS)
) (
    input  logic [NUM_LISTS-1:0] req,
    input  logic [SEL_WIDTH-1:0] last,
    output logic [SEL_WIDTH-1:0] gnt,
    output logic                 gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        // Scan last+1, last+2, ... wrapping; last itself is checked last.
        for (int k = 1; k <= NUM_LISTS; k++) begin
            idx = (int'(last) + k) % NUM_LISTS;
            if (!gnt_vld && req[idx]) begin
                gnt     = SEL_WIDTH'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/linked_list_reader.sv
// Dequeue engine: round-robin pops from non-empty lists, reads the data RAM, streams elements out.
// Latency: pop at cycle t -> out_valid at t+2 when the output FIFO is empty; 1 element/cycle sustained.
// Backpressure: out_ready low fills a 2-entry FIFO; pops stop once in-flight + queued elements would reach 2.
//
// Ports: clk/rst_n; enable, list_mask, empty select eligible lists; pop/pop_sel go to the
//        pointer manager, which returns popped_head; rd_en/rd_addr/rd_data talk to the data RAM;
//        out_valid/out_data/out_qid/out_ready form the downstream stream.
module linked_list_reader
    import linked_list_pkg::*;
#(
    parameter int NUM_ELEMS  = LL_NUM_ELEMS,
    parameter int NUM_LISTS  = LL_NUM_LISTS,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = ll_width(NUM_ELEMS),
    parameter int SEL_WIDTH  = ll_width(NUM_LISTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_LISTS-1:0]  list_mask,
    input  logic [NUM_LISTS-1:0]  empty,
    input  logic [PTR_WIDTH-1:0]  popped_head,
    output logic                  pop,
    output logic [SEL_WIDTH-1:0]  pop_sel,
    output logic [PTR_WIDTH-1:0]  rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_WIDTH-1:0]  out_qid,
    input  logic                  out_ready
);

    logic [NUM_LISTS-1:0]  elig;
    logic [SEL_WIDTH-1:0]  grant;
    logic                  grant_vld;
    logic                  deq;
    logic [2:0]            pending;
    logic                  credit_ok;

    logic [SEL_WIDTH-1:0]  rr_last_q, rr_last_d;
    logic                  inflight_q, inflight_d;
    logic [SEL_WIDTH-1:0]  inflight_qid_q, inflight_qid_d;
    logic [DATA_WIDTH-1:0] fifo_dat_q [2];
    logic [DATA_WIDTH-1:0] fifo_dat_d [2];
    logic [SEL_WIDTH-1:0]  fifo_qid_q [2];
    logic [SEL_WIDTH-1:0]  fifo_qid_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            occ_q, occ_d;

    assign elig = ~empty & list_mask;

    rr_arbiter #(
        .NUM_LISTS (NUM_LISTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_arbiter (
        .req     (elig),
        .last    (rr_last_q),
        .gnt     (grant),
        .gnt_vld (grant_vld)
    );

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = fifo_dat_q[rd_ptr_q];
    assign out_qid   = fifo_qid_q[rd_ptr_q];

    always_comb begin
        deq = out_valid & out_ready;

        // Elements that will still be held (queued or on the RAM read) after this
        // cycle's dequeue; a new pop is allowed only if it keeps that within the FIFO.
        pending   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, deq};
        credit_ok = (pending < 3'd2);

        pop     = enable & grant_vld & credit_ok;
        pop_sel = pop ? grant : '0;
        rd_en   = pop;
        rd_addr = popped_head;

        inflight_d     = pop;
        inflight_qid_d = pop_sel;
        rr_last_d      = pop ? grant : rr_last_q;

        fifo_dat_d = fifo_dat_q;
        fifo_qid_d = fifo_qid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        // RAM data for last cycle's pop lands now; credit guarantees a free slot.
        if (inflight_q) begin
            fifo_dat_d[wr_ptr_q] = rd_data;
            fifo_qid_d[wr_ptr_q] = inflight_qid_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, deq};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q      <= SEL_WIDTH'(NUM_LISTS - 1);
            inflight_q     <= 1'b0;
            inflight_qid_q <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            occ_q          <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_dat_q[i] <= '0;
                fifo_qid_q[i] <= '0;
            end
        end else begin
            rr_last_q      <= rr_last_d;
            inflight_q     <= inflight_d;
            inflight_qid_q <= inflight_qid_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            occ_q          <= occ_d;
            for (int i = 0; i < 2; i++) begin
                fifo_dat_q[i] <= fifo_dat_d[i];
                fifo_qid_q[i] <= fifo_qid_d[i];
            end
        end
    end

endmodule

// File: tb/tb_linked_list_reader.sv
// Bench for linked_list_reader: list manager + RAM environment, element-level reference model.
// Latency: n/a.
// Backpressure: out_ready driven randomly and in directed stalls.
module tb_linked_list_reader;
    import linked_list_pkg::*;

    localparam int NE = 4;
    localparam int NL = 2;
    localparam int DW = 8;
    localparam int PW = 2;
    localparam int SW = 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          enable    = 1'b1;
    logic [NL-1:0] list_mask = '1;
    logic [NL-1:0] empty     = '1;
    logic [PW-1:0] popped_head;
    logic          pop;
    logic [SW-1:0] pop_sel;
    logic [PW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data   = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_qid;
    logic          out_ready = 1'b1;

    always #5 clk = ~clk;

    linked_list_reader #(
        .NUM_ELEMS (NE), .NUM_LISTS (NL), .DATA_WIDTH (DW), .PTR_WIDTH (PW), .SEL_WIDTH (SW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .enable (enable), .list_mask (list_mask),
        .empty (empty), .popped_head (popped_head), .pop (pop), .pop_sel (pop_sel),
        .rd_addr (rd_addr), .rd_en (rd_en), .rd_data (rd_data), .out_valid (out_valid),
        .out_data (out_data), .out_qid (out_qid), .out_ready (out_ready)
    );

    // ---------------- environment: pointer manager lists + data RAM ----------------
    logic [DW-1:0] ram [NE];
    logic [PW-1:0] head_ptr [NL];
    int lq0[$];
    int lq1[$];
    int free_q[$];
    int refill_mode = 0;   // 0 none, 1 random list, 2 list 0 only

    assign popped_head = head_ptr[pop_sel];

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    function automatic int list_size(input int l);
        return (l == 0) ? lq0.size() : lq1.size();
    endfunction

    function automatic int list_head(input int l);
        if (list_size(l) == 0) return 0;
        return (l == 0) ? lq0[0] : lq1[0];
    endfunction

    task automatic list_push(input int l, input int p);
        if (l == 0) lq0.push_back(p); else lq1.push_back(p);
    endtask

    task automatic list_pop(input int l);
        int dummy;
        if (l == 0) dummy = lq0.pop_front(); else dummy = lq1.pop_front();
    endtask

    task automatic env_update();
        for (int i = 0; i < NL; i++) begin
            empty[i]    = (list_size(i) == 0);
            head_ptr[i] = PW'(list_head(i));
        end
    endtask

    task automatic fill_all(input int which);
        int p;
        while (free_q.size() > 0) begin
            p      = free_q.pop_front();
            ram[p] = DW'($urandom);
            list_push((which < 0) ? int'($urandom_range(0, NL - 1)) : which, p);
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every popped element is owed downstream exactly once, in pop
    // order, no earlier than two cycles after its pop; at most two may be owed at once.
    typedef struct {
        logic [DW-1:0] d;
        int            q;
        int            ptr;
        int            rdy;
    } ent_t;

    ent_t oq[$];
    int   m_last   = NL - 1;
    int   cyc      = 0;
    bit   pend_pop = 1'b0;
    int   pend_sel = 0;

    task automatic model_reset();
        foreach (oq[i]) free_q.push_back(oq[i].ptr);
        oq.delete();
        m_last   = NL - 1;
        pend_pop = 1'b0;
    endtask

    always @(negedge clk) begin : cmp_proc
        logic [NL-1:0] e;
        bit            ev, dq, ep;
        int            es, p;
        ent_t          ent;
        if (!rst_n) begin
            chk("reset_out_valid", 32'(out_valid), 32'd0);
        end else begin
            e  = ~empty & list_mask;
            ev = (oq.size() > 0) && (oq[0].rdy <= cyc);
            dq = ev && out_ready;
            ep = enable && (e != '0) && ((oq.size() - int'(dq)) < 2);
            es = 0;
            if (ep) begin
                for (int k = 1; k <= NL; k++) begin
                    if (e[(m_last + k) % NL]) begin
                        es = (m_last + k) % NL;
                        break;
                    end
                end
            end
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                chk("out_data", 32'(out_data), 32'(oq[0].d));
                chk("out_qid", 32'(out_qid), 32'(oq[0].q));
            end
            chk("pop", 32'(pop), 32'(ep));
            chk("rd_en", 32'(rd_en), 32'(ep));
            if (ep) begin
                p = list_head(es);
                chk("pop_sel", 32'(pop_sel), 32'(es));
                chk("rd_addr", 32'(rd_addr), 32'(p));
            end
            if (dq) begin
                ent = oq.pop_front();
                free_q.push_back(ent.ptr);
            end
            if (ep) begin
                oq.push_back('{ram[p], es, p, cyc + 2});
                m_last   = es;
                pend_pop = 1'b1;
                pend_sel = es;
            end
            cyc++;
        end
    end

    // One clock: lands just after the rising edge, applies the manager's side of last cycle.
    task automatic step();
        int p;
        @(posedge clk);
        #1;
        if (pend_pop) begin
            list_pop(pend_sel);
            pend_pop = 1'b0;
        end
        if (refill_mode != 0) begin
            while (free_q.size() > 0) begin
                p      = free_q.pop_front();
                ram[p] = DW'($urandom);
                list_push((refill_mode == 2) ? 0 : int'($urandom_range(0, NL - 1)), p);
            end
        end
        env_update();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : drive
        int p, n0, n1, np, seen;
        for (int i = 0; i < NE; i++) begin
            ram[i] = '0;
            free_q.push_back(i);
        end
        env_update();

        // Reset with both lists empty: everything quiet.
        steps(3);
        @(negedge clk);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_pop_sel", 32'(pop_sel), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_qid", 32'(out_qid), 32'd0);
        step();
        rst_n = 1'b1;

        // Only list 1 holds an element: popped now, visible two cycles later.
        p      = free_q.pop_front();
        ram[p] = 8'hA5;
        list_push(1, p);
        env_update();
        @(negedge clk);
        chk("first_pop", 32'(pop), 32'd1);
        chk("first_pop_sel", 32'(pop_sel), 32'd1);
        step();
        @(negedge clk);
        chk("first_t1_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("first_t2_valid", 32'(out_valid), 32'd1);
        chk("first_t2_qid", 32'(out_qid), 32'd1);
        chk("first_t2_data", 32'(out_data), 32'hA5);
        step();

        // Both lists loaded, downstream always ready: strict alternation starting at 0.
        for (int i = 0; i < 4; i++) begin
            p      = free_q.pop_front();
            ram[p] = DW'(8'h10 + i);
            list_push(i / 2, p);
        end
        env_update();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_pop", 32'(pop), 32'd1);
            chk("alt_sel", 32'(pop_sel), 32'(k % 2));
            step();
        end
        steps(6);

        // Downstream stalled: two pops fill the FIFO, then pop stays low.
        out_ready = 1'b0;
        fill_all(-1);
        env_update();
        np = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            np += int'(pop);
            step();
        end
        chk("stall_pop_count", 32'(np), 32'd2);
        @(negedge clk);
        chk("stall_pop_low", 32'(pop), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        step();
        out_ready   = 1'b1;
        refill_mode = 1;
        steps(12);
        refill_mode = 0;
        steps(10);

        // Mask restricts to list 0; list 1 is granted as soon as it is unmasked.
        list_mask = 2'b01;
        p         = free_q.pop_front();
        ram[p]    = 8'h5C;
        list_push(1, p);
        fill_all(0);
        refill_mode = 2;
        env_update();
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pop && pop_sel == 1'b1) n1++;
            if (pop && pop_sel == 1'b0) n0++;
            step();
        end
        chk("mask_list1_pops", 32'(n1), 32'd0);
        chk("mask_list0_pops", 32'(n0), 32'd6);
        list_mask = 2'b11;
        @(negedge clk);
        chk("unmask_pop", 32'(pop), 32'd1);
        chk("unmask_sel", 32'(pop_sel), 32'd1);
        step();
        refill_mode = 0;
        steps(10);

        // enable drops right after a pop: that element still arrives, nothing more is popped.
        fill_all(0);
        env_update();
        @(negedge clk);
        chk("en_pop", 32'(pop), 32'd1);
        step();
        enable = 1'b0;
        np     = 0;
        seen   = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            np += int'(pop);
            if (out_valid) seen++;
            step();
        end
        chk("en_off_pops", 32'(np), 32'd0);
        chk("en_off_delivered", 32'(seen), 32'd1);

        // Reset with the FIFO full: output clears at once, list 0 wins afterwards.
        enable    = 1'b1;
        out_ready = 1'b0;
        fill_all(1);
        env_update();
        steps(4);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        model_reset();
        fill_all(0);
        env_update();
        steps(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_pop", 32'(pop), 32'd1);
        chk("postrst_sel", 32'(pop_sel), 32'd0);
        step();

        // Randomized traffic with occasional resets.
        refill_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            enable    = ($urandom_range(0, 7) != 0);
            list_mask = NL'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step();
                rst_n = 1'b1;
            end
        end

        refill_mode = 0;
        enable      = 1'b0;
        out_ready   = 1'b1;
        steps(6);
        @(negedge clk);
        chk("final_drained", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
